aes_dec_ctrl: RTL and testbench
===============================

# aes_dec_ctrl

Iterative AES-128 decryption engine: accepts one 128-bit ciphertext block over a valid/ready handshake and sequences the inverse-cipher datapath one round per clock. It reads round keys from the key-expansion store by index and returns the plaintext over a valid/ready handshake. It sits between the block-interface FIFO and the key schedule and reuses the inverse S-box substitution stage in every round.

## Interface
- NR, 10, number of rounds (AES-128); fixed, not user-tunable.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- key_ready  in  1  round-key store holds a valid expanded key.
- in_valid  in  1  ciphertext presented.
- in_ready  out  1  block accepted when in_valid && in_ready at a clock edge.
- in_data  in  128  ciphertext; byte 0 at [127:120], column-major per FIPS-197.
- rk_idx  out  4  round-key index requested, combinational from state.
- rk_data  in  128  round key rk_idx, combinational (same-cycle) read.
- out_valid  out  1  plaintext available; held until consumed.
- out_ready  in  1  downstream accepts when out_valid && out_ready.
- out_data  out  128  plaintext, same byte order.
- busy  out  1  high in ROUND/FINAL.

## Operation
- States: IDLE, ROUND, FINAL, DONE. Registers: 128-bit state, 4-bit round counter rnd.
- IDLE: in_ready = key_ready; rk_idx = 10. On accept: state <= in_data ^ rk_data, rnd <= 9, go ROUND.
- ROUND (rnd 9..1): rk_idx = rnd; state <= InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(state)), rk_data)); rnd decrements; on rnd==1 go FINAL with rnd <= 0.
- FINAL: rk_idx = 0; state <= AddRoundKey(InvSubBytes(InvShiftRows(state)), rk_data); go DONE.
- DONE: out_valid = 1, out_data = state. in_ready = key_ready && out_ready; rk_idx = 10.
  - out_ready with in_valid && key_ready: output consumed and new block loaded in the same edge, go ROUND (back-to-back).
  - out_ready without new input: go IDLE.
  - Otherwise hold; out_data stable.
- in_ready is 0 in ROUND/FINAL; input is never dropped, only stalled.
- key_ready falling mid-block does not abort; the team guarantees keys are not rewritten while busy.
- rk_idx in ROUND/FINAL never leaves 0..9; values 11..15 never driven.

## Timing
- Reset values: state IDLE, out_valid 0, in_ready 0 until the first cycle after reset (then = key_ready), busy 0, rk_idx 10, out_data 0, rnd 0.
- Reset mid-block discards the block, returns to IDLE next cycle; no output produced.
- Latency: accept at edge t; rounds 9..1 at edges t+1..t+9; round 0 at edge t+10; out_valid high from t+10.
- Throughput: one block per 11 cycles with out_ready held high (DONE and load coincide).
- Key read is combinational: rk_data must settle within the same cycle as rk_idx.

## Structure
- Shared package aes_pkg: state encoding (IDLE, ROUND, FINAL, DONE), NR=10, KEY_IDX_W=4, BLOCK_W=128.
- Sub-module aes_dec_round: combinational round built from inv_shift_rows, the existing inverse-SubBytes stage, add-round-key and inv_mix_columns, plus a last_round input that bypasses InvMixColumns. The controller instantiates it once.

## Test plan
- FIPS-197 C.1: key 000102…0f, in_data 69c4e0d86a7b0430d8cdb78070b4c55a → out_data 00112233445566778899aabbccddeeff, out_valid 10 cycles after accept.
- Sequence check: rk_idx reads 10,9,8,…,1,0 on consecutive cycles from the accept cycle; busy high exactly 10 cycles.
- Backpressure: out_ready low 5 cycles in DONE → out_data and out_valid stable, in_ready 0; release → single handshake.
- Back-to-back: two blocks queued, out_ready=1 → second accepted on the edge that consumes the first; outputs 11 cycles apart, both correct.
- key_ready=0 with in_valid=1 → in_ready 0, no accept; raise key_ready → accept next edge.
- rst asserted during round 5 → next cycle IDLE, out_valid 0, rk_idx 10; following block decrypts correctly.

Source files
------------

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 decryption constants, FSM encoding and GF(2^8) helpers.
package aes_pkg;
    localparam int NR        = 10;
    localparam int KEY_IDX_W = 4;
    localparam int BLOCK_W   = 128;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ROUND = 2'd1;
    localparam logic [1:0] FINAL = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    typedef logic [BLOCK_W-1:0] block_t;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254; maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] p;
        logic [7:0] e;
        r = 8'h01;
        p = x;
        e = 8'hfe;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) r = gf_mul(r, p);
            p = gf_mul(p, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [7:0] a;
        a = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
        return gf_inv(a);
    endfunction

    function automatic logic [7:0] imc_coef(input int d);
        return d == 0 ? 8'h0e : d == 1 ? 8'h0b : d == 2 ? 8'h0d : 8'h09;
    endfunction
endpackage

// File: rtl/aes_dec_round.sv
// aes_dec_round: one combinational inverse-cipher round; last_round skips InvMixColumns.
module aes_dec_round
    import aes_pkg::*;
(
    input  logic [BLOCK_W-1:0] blk,
    input  logic [BLOCK_W-1:0] rk,
    input  logic               last_round,
    output logic [BLOCK_W-1:0] res
);
    logic [BLOCK_W-1:0] ark;
    logic [BLOCK_W-1:0] mix;

    // Byte i = 4*col+row sits at [127-8i -: 8]; InvShiftRows pulls row r from column col-r.
    for (genvar i = 0; i < 16; i++) begin : g_byte
        localparam int col = i / 4;
        localparam int row = i % 4;
        localparam int src = 4 * ((col - row + 4) % 4) + row;
        assign ark[127-8*i -: 8] = inv_sbox(blk[127-8*src -: 8]) ^ rk[127-8*i -: 8];
        assign mix[127-8*i -: 8] = gf_mul(ark[127-32*col -: 8], imc_coef((4 - row) % 4))
                                 ^ gf_mul(ark[119-32*col -: 8], imc_coef((5 - row) % 4))
                                 ^ gf_mul(ark[111-32*col -: 8], imc_coef((6 - row) % 4))
                                 ^ gf_mul(ark[103-32*col -: 8], imc_coef((7 - row) % 4));
    end

    assign res = last_round ? ark : mix;
endmodule

// File: rtl/aes_dec_ctrl.sv
// aes_dec_ctrl: iterative AES-128 decryption, one round per clock, valid/ready on both sides.
module aes_dec_ctrl
    import aes_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 key_ready,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BLOCK_W-1:0]   in_data,
    output logic [KEY_IDX_W-1:0] rk_idx,
    input  logic [BLOCK_W-1:0]   rk_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BLOCK_W-1:0]   out_data,
    output logic                 busy
);
    logic [1:0]           st;
    logic [KEY_IDX_W-1:0] rnd;
    block_t               blk;
    block_t               rnd_out;
    logic                 accept;

    assign busy      = st == ROUND || st == FINAL;
    assign out_valid = st == DONE;
    assign out_data  = out_valid ? blk : '0;
    // DONE accepts the next block on the same edge that hands off the current one.
    assign in_ready  = !rst && key_ready && (st == IDLE || (out_valid && out_ready));
    assign accept    = in_valid && in_ready;
    assign rk_idx    = st == ROUND ? rnd : st == FINAL ? '0 : KEY_IDX_W'(NR);

    aes_dec_round u_round (
        .blk        (blk),
        .rk         (rk_data),
        .last_round (st == FINAL),
        .res        (rnd_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            st  <= IDLE;
            blk <= '0;
            rnd <= '0;
        end else if (accept) begin
            st  <= ROUND;
            blk <= in_data ^ rk_data;
            rnd <= KEY_IDX_W'(NR - 1);
        end else if (busy) begin
            blk <= rnd_out;
            rnd <= st == ROUND ? rnd - 1'b1 : rnd;
            st  <= st == FINAL ? DONE : rnd == 1 ? FINAL : ROUND;
        end else if (out_valid && out_ready) begin
            st <= IDLE;
        end
    end
endmodule

// File: tb/tb_aes_dec_ctrl.sv
// tb_aes_dec_ctrl: directed FIPS-197 / SP800-38A vectors with a queue scoreboard on the output side.
module tb_aes_dec_ctrl;
    localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CTA  = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
    localparam logic [127:0] PTA  = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] CTB  = 128'hf5d3d58503b9699de785895a96fdbaaf;
    localparam logic [127:0] PTB  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] CTC  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PTC  = 128'h3243f6a8885a308d313198a2e0370734;

    logic         clk = 0;
    logic         rst;
    logic         key_ready;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [3:0]   rk_idx;
    logic [127:0] rk_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;

    logic [127:0] rk [0:15];
    logic [7:0]   sbox [0:255];
    logic [127:0] exp_q [$];
    int           checks = 0;
    int           failures = 0;
    int           cyc = 0;
    int           last_hs = 0;
    int           prev_hs = 0;

    aes_dec_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .key_ready (key_ready),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .rk_idx    (rk_idx),
        .rk_data   (rk_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    assign rk_data = rk[rk_idx];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    // Forward S-box by brute-force inverse search plus the forward affine map.
    task automatic build_sbox();
        logic [7:0] v;
        logic [7:0] s;
        for (int x = 0; x < 256; x++) begin
            s = 0;
            for (int y = 1; y < 256; y++)
                if (mul(8'(x), 8'(y)) == 8'h01) s = 8'(y);
            v = s ^ {s[6:0], s[7]} ^ {s[5:0], s[7:6]} ^ {s[4:0], s[7:5]} ^ {s[3:0], s[7:4]} ^ 8'h63;
            sbox[x] = v;
        end
    endtask

    task automatic expand(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 16; r++) rk[r] = r <= 10 ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic wait_out(input string name);
        int n;
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(name, 128'(out_valid), 1);
    endtask

    initial forever begin
        logic [127:0] req;
        @(negedge clk);
        if (!rst && out_valid && out_ready) begin
            checks++;
            prev_hs = last_hs;
            last_hs = cyc;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL out_unexpected actual=%h required=no_output", out_data);
            end else begin
                req = exp_q.pop_front();
                if (out_data !== req) begin
                    failures++;
                    $display("FAIL out_data actual=%h required=%h", out_data, req);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1; key_ready = 1; in_valid = 0; out_ready = 0; in_data = '0;
        build_sbox();
        expand(KEY1);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 128'(out_valid), 0);
        chk("rst_busy", 128'(busy), 0);
        chk("rst_rk_idx", 128'(rk_idx), 10);
        chk("rst_out_data", out_data, 0);
        chk("rst_in_ready", 128'(in_ready), 0);
        rst = 0;
        #1;
        chk("idle_in_ready", 128'(in_ready), 1);
        // FIPS-197 C.1 with round-key index sequence and latency
        in_valid = 1; in_data = CT1; exp_q.push_back(PT1);
        #1;
        chk("accept_rk_idx", 128'(rk_idx), 10);
        @(posedge clk);
        #1;
        in_valid = 0;
        for (int k = 9; k >= 0; k--) begin
            chk("seq_rk_idx", 128'(rk_idx), 128'(k));
            chk("seq_busy", 128'(busy), 1);
            chk("seq_out_valid", 128'(out_valid), 0);
            @(posedge clk);
            #1;
        end
        chk("latency_out_valid", 128'(out_valid), 1);
        chk("done_busy", 128'(busy), 0);
        // backpressure
        for (int k = 0; k < 5; k++) begin
            chk("bp_out_valid", 128'(out_valid), 1);
            chk("bp_out_data", out_data, PT1);
            chk("bp_in_ready", 128'(in_ready), 0);
            @(posedge clk);
            #1;
        end
        out_ready = 1;
        @(posedge clk);
        #1;
        out_ready = 0;
        chk("single_handshake", 128'(out_valid), 0);
        chk("bp_q_empty", 128'(exp_q.size()), 0);
        // key_ready gating
        key_ready = 0; in_valid = 1; in_data = CT1;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("kr_in_ready", 128'(in_ready), 0);
            @(posedge clk);
            #1;
            chk("kr_no_accept", 128'(busy), 0);
        end
        key_ready = 1;
        #1;
        chk("kr_in_ready_up", 128'(in_ready), 1);
        exp_q.push_back(PT1);
        @(posedge clk);
        #1;
        in_valid = 0;
        chk("kr_accept", 128'(busy), 1);
        out_ready = 1;
        wait_out("kr_done");
        @(posedge clk);
        #1;
        // back-to-back with a second key
        expand(KEY2);
        in_valid = 1; in_data = CTA; exp_q.push_back(PTA);
        @(posedge clk);
        #1;
        in_data = CTB; exp_q.push_back(PTB);
        wait_out("b2b_first");
        chk("b2b_in_ready", 128'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 0;
        chk("b2b_second_loaded", 128'(busy), 1);
        wait_out("b2b_second");
        @(posedge clk);
        #1;
        chk("b2b_gap", 128'(last_hs - prev_hs), 11);
        chk("b2b_idle", 128'(out_valid), 0);
        // reset during round 5 discards the block
        in_valid = 1; in_data = CTC;
        @(posedge clk);
        #1;
        in_valid = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        chk("mid_rk_idx", 128'(rk_idx), 5);
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        chk("mrst_busy", 128'(busy), 0);
        chk("mrst_out_valid", 128'(out_valid), 0);
        chk("mrst_rk_idx", 128'(rk_idx), 10);
        repeat (12) begin
            @(posedge clk);
            #1;
        end
        chk("mrst_no_output", 128'(out_valid), 0);
        in_valid = 1; in_data = CTC; exp_q.push_back(PTC);
        @(posedge clk);
        #1;
        in_valid = 0;
        wait_out("post_rst_done");
        @(posedge clk);
        #1;
        chk("scoreboard_empty", 128'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
